// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - phase encoding and width helper shared by the wash sequencer
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_DRAIN = 3'd3,
    PH_SPIN  = 3'd4,
    PH_RINSE = 3'd5,
    PH_DONE  = 3'd6
  } phase_e;

  function automatic int rw_width(input int rinse_max);
    return (rinse_max < 1) ? 1 : $clog2(rinse_max + 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter; expire flags the enabled step off remain==1
module phase_timer #(
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              en,
  output logic [TIME_W-1:0] remain,
  output logic              expire
);

  logic [TIME_W-1:0] remain_q, remain_d;

  // load wins over the decrement so a phase change replaces the final step
  always_comb begin
    remain_d = remain_q;
    if (load) begin
      remain_d = load_val;
    end else if (en && (remain_q != '0)) begin
      remain_d = remain_q - TIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain_q <= '0;
    end else begin
      remain_q <= remain_d;
    end
  end

  assign remain = remain_q;
  assign expire = en && (remain_q == TIME_W'(1));

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - wash program FSM: FILL/WASH/DRAIN/SPIN, rinse rounds, timed DONE beep
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int TIME_W    = 8,
  parameter int RINSE_MAX = 3,
  parameter int T_FILL    = 4,
  parameter int T_WASH    = 9,
  parameter int T_RINSE   = 6,
  parameter int T_DRAIN   = 3,
  parameter int T_SPIN    = 5,
  parameter int BEEP_T    = 5,
  parameter int RW        = rw_width(RINSE_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              start,
  input  logic              lid_open,
  input  logic [1:0]        level,
  input  logic [RW-1:0]     rinse_cnt,
  output logic [2:0]        phase,
  output logic [TIME_W-1:0] remain,
  output logic [RW-1:0]     rinse_left,
  output logic              running,
  output logic              paused,
  output logic              hold,
  output logic              beep
);

  if (T_FILL < 1 || T_WASH < 1 || T_RINSE < 1 || T_DRAIN < 1 || T_SPIN < 1 || BEEP_T < 1) begin : g_bad_time
    $error("wash_sequencer: every phase duration must be at least one tick");
  end
  if (T_FILL * 4 > (2 ** TIME_W) - 1) begin : g_fill_overflow
    $error("wash_sequencer: T_FILL*(level+1) does not fit in TIME_W bits");
  end

  phase_e            phase_q, phase_d;
  logic [RW-1:0]     rinse_left_q, rinse_left_d;
  logic [1:0]        level_s_q, level_s_d;
  logic              in_rinse_q, in_rinse_d;
  logic              paused_q, paused_d;
  logic              hold_q, hold_d;
  logic              beep_q, beep_d;

  logic              t_load, t_en, t_expire;
  logic [TIME_W-1:0] t_val, t_remain;

  function automatic logic [TIME_W-1:0] fill_time(input logic [1:0] lv);
    return TIME_W'(T_FILL) * (TIME_W'(lv) + TIME_W'(1));
  endfunction

  function automatic logic is_running(input phase_e p);
    return p inside {PH_FILL, PH_WASH, PH_DRAIN, PH_SPIN, PH_RINSE};
  endfunction

  phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .remain   (t_remain),
    .expire   (t_expire)
  );

  always_comb begin
    phase_d      = phase_q;
    rinse_left_d = rinse_left_q;
    level_s_d    = level_s_q;
    in_rinse_d   = in_rinse_q;
    paused_d     = paused_q;
    beep_d       = beep_q;
    t_load       = 1'b0;
    t_val        = '0;
    t_en         = 1'b0;

    case (phase_q)
      PH_IDLE: begin
        if (start && !lid_open) begin
          phase_d      = PH_FILL;
          t_load       = 1'b1;
          t_val        = fill_time(level);
          level_s_d    = level;
          in_rinse_d   = 1'b0;
          rinse_left_d = (int'(rinse_cnt) > RINSE_MAX) ? RW'(RINSE_MAX) : rinse_cnt;
        end
      end
      PH_DONE: begin
        if (start) begin
          phase_d      = PH_IDLE;
          t_load       = 1'b1;
          rinse_left_d = '0;
          level_s_d    = '0;
          in_rinse_d   = 1'b0;
          paused_d     = 1'b0;
          beep_d       = 1'b0;
        end else begin
          t_en = tick;
          if (t_expire) beep_d = 1'b0;
        end
      end
      default: begin
        // a start pulse in a running phase only toggles pause and swallows any tick
        if (start) begin
          paused_d = !paused_q;
        end else begin
          t_en = tick && !paused_q && !lid_open;
          if (t_expire) begin
            t_load = 1'b1;
            case (phase_q)
              PH_FILL: begin
                phase_d = in_rinse_q ? PH_RINSE : PH_WASH;
                t_val   = in_rinse_q ? TIME_W'(T_RINSE) : TIME_W'(T_WASH);
              end
              PH_WASH, PH_RINSE: begin
                phase_d = PH_DRAIN;
                t_val   = TIME_W'(T_DRAIN);
              end
              PH_DRAIN: begin
                phase_d = PH_SPIN;
                t_val   = TIME_W'(T_SPIN);
              end
              default: begin
                if (rinse_left_q != '0) begin
                  phase_d      = PH_FILL;
                  t_val        = fill_time(level_s_q);
                  rinse_left_d = rinse_left_q - RW'(1);
                  in_rinse_d   = 1'b1;
                end else begin
                  phase_d = PH_DONE;
                  t_val   = TIME_W'(BEEP_T);
                  beep_d  = 1'b1;
                end
              end
            endcase
          end
        end
      end
    endcase

    hold_d = is_running(phase_d) && (paused_d || lid_open);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH_IDLE;
      rinse_left_q <= '0;
      level_s_q    <= '0;
      in_rinse_q   <= 1'b0;
      paused_q     <= 1'b0;
      hold_q       <= 1'b0;
      beep_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      rinse_left_q <= rinse_left_d;
      level_s_q    <= level_s_d;
      in_rinse_q   <= in_rinse_d;
      paused_q     <= paused_d;
      hold_q       <= hold_d;
      beep_q       <= beep_d;
    end
  end

  assign phase      = phase_q;
  assign remain     = t_remain;
  assign rinse_left = rinse_left_q;
  assign running    = is_running(phase_q);
  assign paused     = paused_q;
  assign hold       = hold_q;
  assign beep       = beep_q;

endmodule
